// File: rtl/vectored_intr_ctrl.sv
// vectored_intr_ctrl: fixed-priority vectored interrupt controller with edge/level sources and per-source masking.
// Define VIC_NESTING_EN to let a higher-priority source preempt a service in progress.
module vectored_intr_ctrl #(
  parameter int unsigned      N_SRC      = 8,
  parameter logic [N_SRC-1:0] LEVEL_MASK = '0,
  parameter logic [31:0]      VEC_BASE   = 32'h0000_0008,
  parameter int unsigned      VEC_STRIDE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] intr,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] in_service,
  output logic             irq,
  input  logic             ack,
  output logic [4:0]       id,
  output logic [31:0]      vector,
  input  logic             eoi
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state_q, state_d;
  logic [N_SRC-1:0] intr_q, pend_q, pend_d, mask_q, isv_q, isv_d, elig, clr;
  logic [4:0] id_q, id_d, win, low_isv;
  logic [31:0] vec_q, vec_d;
  logic win_v, take;
  always_comb begin
    elig = pend_q & ~mask_q & ~isv_q;
    win = '0;
    win_v = 1'b0;
    low_isv = 5'd31;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win = 5'(i);
        win_v = 1'b1;
      end
      if (isv_q[i]) low_isv = 5'(i);
    end
    state_d = state_q;
    id_d = id_q;
    vec_d = vec_q;
    isv_d = isv_q;
    clr = '0;
    take = 1'b0;
    case (state_q)
      IDLE: take = win_v;
      REQ: if (ack) begin
        state_d = SERVICE;
        isv_d = isv_q | (N_SRC'(1) << id_q);
        clr = ~LEVEL_MASK & (N_SRC'(1) << id_q);
      end
      SERVICE: begin
        if (eoi) isv_d = isv_q & ~(N_SRC'(1) << low_isv);
        if (isv_d == '0) state_d = IDLE;
`ifdef VIC_NESTING_EN
        else take = win_v && (win < low_isv);
`endif
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = REQ;
      id_d = win;
      vec_d = VEC_BASE + 32'(win) * VEC_STRIDE;
    end
    // a fresh edge wins over the ack clear of the same bit
    pend_d = (LEVEL_MASK & intr) | (~LEVEL_MASK & ((pend_q & ~clr) | (intr & ~intr_q)));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      id_q <= '0;
      vec_q <= VEC_BASE;
      pend_q <= '0;
      isv_q <= '0;
      mask_q <= '0;
      intr_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      vec_q <= vec_d;
      pend_q <= pend_d;
      isv_q <= isv_d;
      mask_q <= mask_we ? mask_wdata : mask_q;
      intr_q <= intr;
    end
  end
  assign mask = mask_q;
  assign pending = pend_q;
  assign in_service = isv_q;
  assign irq = state_q == REQ;
  assign id = id_q;
  assign vector = vec_q;
endmodule

// File: tb/tb_vectored_intr_ctrl.sv
// tb_vectored_intr_ctrl: directed checks of vectored_intr_ctrl with source 0 level-sensitive, others edge.
module tb_vectored_intr_ctrl;
  logic clock = 1'b0, reset = 1'b1, mask_we = 1'b0, ack = 1'b0, eoi = 1'b0;
  logic [7:0] intr = '0, mask_wdata = '0, mask, pending, in_service;
  logic irq;
  logic [4:0] id;
  logic [31:0] vector;
  int checks = 0, errors = 0;
  vectored_intr_ctrl #(.N_SRC(8), .LEVEL_MASK(8'h01)) dut (
    .clock(clock), .reset(reset), .intr(intr), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .mask(mask), .pending(pending), .in_service(in_service), .irq(irq), .ack(ack),
    .id(id), .vector(vector), .eoi(eoi)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    tick(); tick();
    chk("rst_irq", 32'(irq), 0); chk("rst_id", 32'(id), 0); chk("rst_vec", vector, 32'h08);
    chk("rst_pend", 32'(pending), 0); chk("rst_isv", 32'(in_service), 0); chk("rst_mask", 32'(mask), 0);
    reset = 1'b0;
    // single edge pulse on source 3
    intr = 8'h08; tick(); intr = 8'h00;
    chk("p3_pend", 32'(pending), 32'h08); chk("p3_irq_early", 32'(irq), 0);
    tick();
    chk("p3_irq", 32'(irq), 1); chk("p3_id", 32'(id), 3); chk("p3_vec", vector, 32'h20);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("p3_ack_irq", 32'(irq), 0); chk("p3_ack_pend", 32'(pending), 0); chk("p3_ack_isv", 32'(in_service), 32'h08);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("p3_eoi_isv", 32'(in_service), 0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("idle_ack_isv", 32'(in_service), 0); chk("idle_ack_irq", 32'(irq), 0);
    // simultaneous 5 and 1
    intr = 8'h22; tick(); intr = 8'h00; tick();
    chk("p1_id", 32'(id), 1); chk("p1_vec", vector, 32'h10);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("p1_pend", 32'(pending), 32'h20);
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    chk("p5_irq", 32'(irq), 1); chk("p5_id", 32'(id), 5); chk("p5_vec", vector, 32'h30);
    ack = 1'b1; tick(); ack = 1'b0; eoi = 1'b1; tick(); eoi = 1'b0;
    chk("p5_isv", 32'(in_service), 0);
    // masked source 2
    mask_we = 1'b1; mask_wdata = 8'h04; tick(); mask_we = 1'b0;
    chk("mask_wr", 32'(mask), 32'h04);
    intr = 8'h04; tick(); intr = 8'h00; tick(); tick();
    chk("m2_irq", 32'(irq), 0); chk("m2_pend", 32'(pending), 32'h04);
    mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
    chk("m2_irq_edge_m", 32'(irq), 0);
    tick();
    chk("m2_irq_on", 32'(irq), 1); chk("m2_id", 32'(id), 2);
    ack = 1'b1; tick(); ack = 1'b0; eoi = 1'b1; tick(); eoi = 1'b0;
    // level source 0 held high
    intr = 8'h01; tick(); tick();
    chk("l0_id", 32'(id), 0); chk("l0_vec", vector, 32'h08);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("l0_pend_held", 32'(pending), 32'h01);
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    chk("l0_reassert", 32'(irq), 1); chk("l0_id2", 32'(id), 0);
    ack = 1'b1; tick(); ack = 1'b0; intr = 8'h00; eoi = 1'b1; tick(); eoi = 1'b0; tick();
    chk("l0_gone", 32'(irq), 0);
    // edge source 4 held high does not reassert
    intr = 8'h10; tick(); tick();
    chk("e4_id", 32'(id), 4);
    ack = 1'b1; tick(); ack = 1'b0; eoi = 1'b1; tick(); eoi = 1'b0; tick(); tick();
    chk("e4_no_reassert", 32'(irq), 0); chk("e4_pend", 32'(pending), 0);
    intr = 8'h00; tick();
    // new edge coincident with ack clear keeps pending; eoi ignored in REQ
    intr = 8'h08; tick(); intr = 8'h00; tick();
    intr = 8'h08; ack = 1'b1; tick(); intr = 8'h00; ack = 1'b0;
    chk("race_pend", 32'(pending), 32'h08);
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    chk("race_req", 32'(irq), 1);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("req_eoi_ign", 32'(irq), 1);
    ack = 1'b1; tick(); ack = 1'b0; eoi = 1'b1; tick(); eoi = 1'b0;
    // source 2 arrives during service of source 4
    intr = 8'h10; tick(); intr = 8'h00; tick();
    ack = 1'b1; tick(); ack = 1'b0;
    intr = 8'h04; tick(); intr = 8'h00; tick();
`ifdef VIC_NESTING_EN
    chk("nest_irq", 32'(irq), 1); chk("nest_id", 32'(id), 2);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("nest_isv", 32'(in_service), 32'h14);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("nest_eoi1", 32'(in_service), 32'h10);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("nest_eoi2", 32'(in_service), 0);
`else
    chk("nonest_irq", 32'(irq), 0); chk("nonest_isv", 32'(in_service), 32'h10);
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    chk("nonest_irq2", 32'(irq), 1); chk("nonest_id", 32'(id), 2); chk("nonest_vec", vector, 32'h18);
    ack = 1'b1; tick(); ack = 1'b0; eoi = 1'b1; tick(); eoi = 1'b0;
`endif
    // reset in the middle of a request
    intr = 8'h40; tick(); intr = 8'h00; tick();
    chk("r6_vec", vector, 32'h38);
    intr = 8'h02; tick(); intr = 8'h00;
    chk("r6_frozen_id", 32'(id), 6); chk("r6_frozen_irq", 32'(irq), 1);
    reset = 1'b1; ack = 1'b1; mask_we = 1'b1; mask_wdata = 8'hff; intr = 8'hff; tick();
    reset = 1'b0; ack = 1'b0; mask_we = 1'b0; intr = 8'h00;
    chk("rr_irq", 32'(irq), 0); chk("rr_pend", 32'(pending), 0); chk("rr_isv", 32'(in_service), 0);
    chk("rr_vec", vector, 32'h08); chk("rr_mask", 32'(mask), 0); chk("rr_id", 32'(id), 0);
    tick();
    chk("rr_quiet", 32'(irq), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vectored_intr_ctrl.md
VECTORED_INTR_CTRL -- requirements
Module: vectored_intr_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 8, number of interrupt sources (legal 1..32).
REQ-002 SHALL have parameter LEVEL_MASK, default 0, N_SRC bits; bit i = 1 makes source i level-sensitive, 0 makes it rising-edge.
REQ-003 SHALL have parameter VEC_BASE, default 32'h0000_0008, handler address of source 0.
REQ-004 SHALL have parameter VEC_STRIDE, default 8, byte spacing between handler slots (jump plus delay slot).
REQ-005 SHALL have ports:
  clock  in  1  sole clock, rising edge.
  reset  in  1  synchronous, active-high reset.
  intr  in  N_SRC  raw requests, synchronous to clock.
  mask_we  in  1  mask register write strobe.
  mask_wdata  in  N_SRC  new mask; 1 = source disabled.
  mask  out  N_SRC  current mask register.
  pending  out  N_SRC  latched pending bits.
  in_service  out  N_SRC  sources currently being serviced.
  irq  out  1  interrupt request to CPU, registered.
  ack  in  1  CPU takes the interrupt (redirects pc, saves epc).
  id  out  5  winning source index, valid while irq = 1.
  vector  out  32  handler address, valid while irq = 1.
  eoi  in  1  CPU executed eret; end of service.

Function
REQ-006 SHALL register intr into intr_q each cycle; edge source i sets pending[i] when intr[i] & ~intr_q[i].
REQ-007 SHALL set level source pending[i] to intr[i] every cycle, except a clear on ack applies only to edge sources.
REQ-008 SHALL latch pending regardless of mask; mask gates arbitration only.
REQ-009 SHALL arbitrate with fixed priority, lowest index highest, among pending & ~mask & ~in_service.
REQ-010 SHALL implement states IDLE, REQ, SERVICE; irq = 1 exactly in REQ.
REQ-011 IDLE -> REQ when any source is eligible; id latched to the winner and vector = VEC_BASE + id*VEC_STRIDE (32-bit wrap).
REQ-012 SHALL hold id and vector frozen in REQ; later higher-priority arrivals, mask writes or level drop do not withdraw or change the request.
REQ-013 REQ with ack -> SERVICE: in_service[id] set; pending[id] cleared if edge source; irq low the following cycle.
REQ-014 SHALL ignore ack outside REQ and eoi outside SERVICE.
REQ-015 SERVICE with eoi clears the highest-priority set in_service bit; -> IDLE when in_service becomes zero, otherwise stays SERVICE.
REQ-016 SHALL give a new edge priority over the ack clear when both hit the same pending bit in one cycle (bit stays 1).
REQ-017 mask_we SHALL update mask at that clock edge; arbitration uses the new mask from the next cycle.
REQ-018 Latency: intr first sampled high at edge k -> pending at edge k -> irq high after edge k+1.

Reset
REQ-019 reset SHALL, at the clock edge, force: state IDLE, irq 0, id 0, vector VEC_BASE, pending 0, in_service 0, mask 0 (all enabled), intr_q 0.
REQ-020 reset SHALL override ack, eoi, mask_we and intr in the same cycle, including mid-REQ or mid-SERVICE.

Configuration
REQ-021 With macro VIC_NESTING_EN defined: in SERVICE, an eligible source with index lower than the lowest set in_service bit SHALL move to REQ (irq 1); ack returns to SERVICE with that bit also set.
REQ-022 Without VIC_NESTING_EN: no transition SERVICE -> REQ; in_service holds at most one bit.

Verification (N_SRC=8, LEVEL_MASK=8'h01, defaults otherwise)
REQ-023 One-cycle pulse intr[3] -> irq=1 two edges later, id=3, vector=0x20; ack -> irq=0, pending[3]=0, in_service=0x08; eoi -> in_service=0, IDLE.
REQ-024 intr[5], intr[1] rise same cycle -> id=1, vector=0x10; after ack+eoi, id=5, vector=0x30.
REQ-025 mask=0x04, pulse intr[2] -> irq stays 0, pending=0x04; write mask=0 -> irq=1 two edges after mask_we, id=2.
REQ-026 intr[0] (level) held high through ack+eoi -> irq reasserts, id=0, vector=0x08; intr[4] (edge) held high -> no reassert after its eoi.
REQ-027 In SERVICE of source 4, pulse intr[2]: with VIC_NESTING_EN -> irq=1, id=2, in_service=0x14 after ack; without -> irq=0 until eoi, then id=2.
REQ-028 Assert reset while irq=1 -> next cycle irq=0, pending=0, in_service=0, vector=0x08.
